// File: rtl/data_mem_sync.sv
// rtl/data_mem_sync.sv - sync-read data memory with write-first forwarding, result mux and reset clear sweep (optional parity: DATAMEM_PARITY_EN)
module data_mem_sync #(
    parameter int            DW       = 8,
    parameter int            AW       = 8,
    parameter int            DEPTH    = 2**AW,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic          ReadEn,
    input  logic          MemToReg,
    input  logic [DW-1:0] ALUdata,
    input  logic [AW-1:0] DataAddress,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          ReadValid,
    output logic          Busy,
`ifdef DATAMEM_PARITY_EN
    output logic          ParityErr,
`endif
    output logic          AddrErr
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

`ifdef DATAMEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    // One extra bit so DEPTH == 2**AW is representable in the range compare
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [MW-1:0] Core [DEPTH];

    logic [0:0]    state;
    logic [AW-1:0] ptr;

    logic          ready;
    logic          addr_ok;
    logic          mem_wr;
    logic          rd_mem;
    logic          fwd;
    logic [MW-1:0] rd_word;
    logic [MW-1:0] init_word;
    logic [MW-1:0] wr_word;

    assign ready   = (state == ST_READY);
    assign addr_ok = ({1'b0, DataAddress} < DEPTH_W);
    assign mem_wr  = ready & WriteEn & addr_ok;
    assign rd_mem  = ready & ReadEn & MemToReg;
    // Only one address port, so a simultaneous write always targets the read word
    assign fwd     = rd_mem & WriteEn & addr_ok;
    assign rd_word = addr_ok ? Core[DataAddress] : '0;
    assign Busy    = (state == ST_CLEAR);

`ifdef DATAMEM_PARITY_EN
    // Even parity: stored bit makes the total number of ones even
    assign init_word = {^INIT_VAL, INIT_VAL};
    assign wr_word   = {^DataIn, DataIn};
`else
    assign init_word = INIT_VAL;
    assign wr_word   = DataIn;
`endif

    // Clear sweep sequencer: one word per cycle after reset release, then READY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else if (state == ST_CLEAR) begin
            if (ptr == LAST_PTR) begin
                state <= ST_READY;
                ptr   <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Memory write port: sweep owns it during CLEAR, untouched while Reset is held
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (!ready) begin
                Core[ptr] <= init_word;
            end else if (mem_wr) begin
                Core[DataAddress] <= wr_word;
            end
        end
    end

    // Registered result mux: memory word (write-first) or ALU pass-through
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOut   <= '0;
            ReadValid <= 1'b0;
        end else if (ready) begin
            ReadValid <= ReadEn;
            if (ReadEn) begin
                if (!MemToReg) begin
                    DataOut <= ALUdata;
                end else if (!addr_ok) begin
                    DataOut <= '0;
                end else if (fwd) begin
                    DataOut <= DataIn;
                end else begin
                    DataOut <= rd_word[DW-1:0];
                end
            end
        end else begin
            ReadValid <= 1'b0;
        end
    end

    // Sticky out-of-range flag; ALU pass-through requests do not check the address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            AddrErr <= 1'b0;
        end else if (ready && !addr_ok && (WriteEn || (ReadEn && MemToReg))) begin
            AddrErr <= 1'b1;
        end
    end

`ifdef DATAMEM_PARITY_EN
    // Parity flag registered with DataOut; forwarded data is freshly encoded so never flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ParityErr <= 1'b0;
        end else if (ready && ReadEn) begin
            ParityErr <= rd_mem & addr_ok & ~WriteEn & (^rd_word);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_sync.sv
// tb/tb_data_mem_sync.sv - directed self-checking bench for data_mem_sync (DEPTH=16 and DEPTH=12 instances)
module tb_data_mem_sync;

    logic       Clk;
    logic       Reset;
    logic       WriteEn;
    logic       ReadEn;
    logic       MemToReg;
    logic [7:0] ALUdata;
    logic [3:0] DataAddress;
    logic [7:0] DataIn;

    logic [7:0] do16, do12;
    logic       rv16, rv12;
    logic       busy16, busy12;
    logic       ae16, ae12;
`ifdef DATAMEM_PARITY_EN
    logic       pe16, pe12;
`endif

    int tests_run;
    int tests_failed;
    int cnt16;
    int cnt12;

    data_mem_sync #(.DW(8), .AW(4), .DEPTH(16), .INIT_VAL(8'hA5)) u_dut16 (
        .Clk         (Clk),
        .Reset       (Reset),
        .WriteEn     (WriteEn),
        .ReadEn      (ReadEn),
        .MemToReg    (MemToReg),
        .ALUdata     (ALUdata),
        .DataAddress (DataAddress),
        .DataIn      (DataIn),
        .DataOut     (do16),
        .ReadValid   (rv16),
        .Busy        (busy16),
`ifdef DATAMEM_PARITY_EN
        .ParityErr   (pe16),
`endif
        .AddrErr     (ae16)
    );

    data_mem_sync #(.DW(8), .AW(4), .DEPTH(12), .INIT_VAL(8'hC3)) u_dut12 (
        .Clk         (Clk),
        .Reset       (Reset),
        .WriteEn     (WriteEn),
        .ReadEn      (ReadEn),
        .MemToReg    (MemToReg),
        .ALUdata     (ALUdata),
        .DataAddress (DataAddress),
        .DataIn      (DataIn),
        .DataOut     (do12),
        .ReadValid   (rv12),
        .Busy        (busy12),
`ifdef DATAMEM_PARITY_EN
        .ParityErr   (pe12),
`endif
        .AddrErr     (ae12)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count sample points with Busy high, starting at the sample after the last reset edge
    task automatic count_busy(input bit chk_rv);
        cnt16 = 0;
        cnt12 = 0;
        for (int k = 0; k < 40 && (busy16 || busy12); k++) begin
            if (busy16) cnt16++;
            if (busy12) cnt12++;
            if (chk_rv && busy16) check("busy_rv16", rv16, 1'b0);
            tick();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset = 1'b1; WriteEn = 1'b0; ReadEn = 1'b0; MemToReg = 1'b0;
        ALUdata = 8'h00; DataAddress = 4'h0; DataIn = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_do", do16, 8'h00);
        check("rst_rv", rv16, 1'b0);
        check("rst_ae", ae16, 1'b0);
        check("rst_busy", busy16, 1'b1);

        // Busy length after a one-cycle reset pulse
        Reset = 1'b0;
        count_busy(1'b0);
        check("busy_len16", cnt16, 16);
        check("busy_len12", cnt12, 12);

        // Full-rate reads of every cleared word; DEPTH=12 instance flags 12..15
        for (int i = 0; i < 16; i++) begin
            ReadEn = 1'b1; MemToReg = 1'b1; DataAddress = 4'(i);
            tick();
            check("clr_rd16", do16, 8'hA5);
            check("clr_rv16", rv16, 1'b1);
            check("clr_rd12", do12, (i < 12) ? 8'hC3 : 8'h00);
            check("clr_ae12", ae12, (i >= 12) ? 1'b1 : 1'b0);
        end
        ReadEn = 1'b0;
        tick();
        check("idle_rv", rv16, 1'b0);
        check("idle_hold", do16, 8'hA5);

        // Write then read back
        WriteEn = 1'b1; DataIn = 8'h3C; DataAddress = 4'd5;
        tick();
        check("wr_rv", rv16, 1'b0);
        WriteEn = 1'b0; ReadEn = 1'b1; MemToReg = 1'b1;
        tick();
        check("wr_rd", do16, 8'h3C);

        // Write-first forwarding, then the write must have landed
        WriteEn = 1'b1; DataIn = 8'h77; DataAddress = 4'd9;
        tick();
        check("fwd_do", do16, 8'h77);
        check("fwd_rv", rv16, 1'b1);
        WriteEn = 1'b0;
        tick();
        check("fwd_mem", do16, 8'h77);

        // ALU pass-through
        MemToReg = 1'b0; ALUdata = 8'h42;
        tick();
        check("alu_do", do16, 8'h42);
        check("alu_rv", rv16, 1'b1);

        // Alternating sources at full rate
        for (int i = 0; i < 6; i++) begin
            MemToReg = (i % 2 == 0);
            ALUdata = 8'h10 + 8'(i);
            DataAddress = 4'd5;
            tick();
            check("alt_do", do16, (i % 2 == 0) ? 8'h3C : (8'h10 + 8'(i)));
            check("alt_rv", rv16, 1'b1);
        end

        // Reset at sweep cycle 7; requests during Busy are ignored
        WriteEn = 1'b1; DataIn = 8'hFF; DataAddress = 4'd5; ReadEn = 1'b1; MemToReg = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (7) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        count_busy(1'b1);
        check("rebusy_len16", cnt16, 16);
        check("rebusy_ae12", ae12, 1'b0);
        WriteEn = 1'b0; ReadEn = 1'b1; MemToReg = 1'b1; DataAddress = 4'd5;
        tick();
        check("busy_nowr", do16, 8'hA5);
        DataAddress = 4'd0;
        tick();
        check("resweep_a0", do16, 8'hA5);

        // ALU request with out-of-range address is not checked
        MemToReg = 1'b0; ALUdata = 8'h99; DataAddress = 4'd14;
        tick();
        check("alu_oor_do", do12, 8'h99);
        check("alu_oor_ae", ae12, 1'b0);

        // Out-of-range write and read on the DEPTH=12 instance
        ReadEn = 1'b0; WriteEn = 1'b1; DataIn = 8'h5A; DataAddress = 4'd13;
        tick();
        check("oor_wr_ae12", ae12, 1'b1);
        check("oor_wr_ae16", ae16, 1'b0);
        WriteEn = 1'b0; ReadEn = 1'b1; MemToReg = 1'b1; DataAddress = 4'd14;
        tick();
        check("oor_rd_do", do12, 8'h00);
        check("oor_rd_rv", rv12, 1'b1);
        ReadEn = 1'b0;
        repeat (3) tick();
        check("oor_sticky", ae12, 1'b1);

`ifdef DATAMEM_PARITY_EN
        // Corrupt one stored bit and read it back; neighbour stays clean
        u_dut16.Core[3][0] = ~u_dut16.Core[3][0];
        ReadEn = 1'b1; MemToReg = 1'b1; DataAddress = 4'd3;
        tick();
        check("par_do", do16, 8'hA4);
        check("par_err", pe16, 1'b1);
        DataAddress = 4'd4;
        tick();
        check("par_clean_do", do16, 8'hA5);
        check("par_clean", pe16, 1'b0);
        ReadEn = 1'b0;
`endif

        // Only reset clears the sticky flag
        Reset = 1'b1;
        tick();
        check("rst2_ae12", ae12, 1'b0);
        check("rst2_rv12", rv12, 1'b0);
        check("rst2_busy", busy12, 1'b1);
        Reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_sync.md
Name: data_mem_sync

Overview:
- Parametrised successor to the single-cycle data memory in the datapath write-back stage.
- Synchronous-read RAM with 1-cycle registered output, write-first forwarding, and a registered ALU/memory result mux aligned to the same latency.
- Self-clearing on reset via an internal sweep sequencer, with a Busy indication.
- Sits between the ALU and the register-file write port.

Parameters:
- DW, 8, data word width in bits.
- AW, 8, address width in bits.
- DEPTH, 2**AW, number of words; legal range 2..2**AW.
- INIT_VAL, 0, DW-bit value written to every word by the clear sweep.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- WriteEn  input  1  write request this cycle.
- ReadEn  input  1  read/result request this cycle.
- MemToReg  input  1  result source select: 1 = memory word, 0 = ALUdata.
- ALUdata  input  DW  ALU result to pass through.
- DataAddress  input  AW  word address for read and write.
- DataIn  input  DW  write data.
- DataOut  output  DW  registered result.
- ReadValid  output  1  DataOut holds the result of a request accepted the previous cycle.
- Busy  output  1  clear sweep in progress; requests ignored.
- AddrErr  output  1  sticky flag: an access hit an address >= DEPTH.

Behaviour:
- Reset (sampled high at an edge):
  - state <= CLEAR, sweep pointer <= 0.
  - DataOut <= 0, ReadValid <= 0, AddrErr <= 0, Busy = 1.
  - Memory contents are not touched while Reset is held.
- States:
  - CLEAR: each edge with Reset=0 writes INIT_VAL to Core[ptr] and increments ptr. When ptr == DEPTH-1 the write occurs and state <= READY.
  - Busy is high for exactly DEPTH cycles after Reset deasserts.
  - READY: normal operation.
- Reset reasserted during CLEAR restarts the sweep at address 0.
- Reset during READY discards any in-flight read; ReadValid is 0 next cycle.
- In CLEAR, WriteEn and ReadEn are ignored: no write, ReadValid stays 0, DataOut holds.
- Write (READY, WriteEn=1, addr < DEPTH): Core[addr] <= DataIn at the edge.
- Request accepted (READY, ReadEn=1) at edge N:
  - ReadValid = 1 during cycle N+1.
  - DataOut = Core[addr] if MemToReg=1, else ALUdata, both as sampled at N.
- Read-during-write, same address, same edge: DataOut = DataIn (write-first).
- ReadEn=0: ReadValid <= 0 and DataOut holds its previous value.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**AW):
  - Write is dropped.
  - A memory read returns 0 with ReadValid=1.
  - AddrErr <= 1 and stays set until Reset.
  - With MemToReg=0, the address is not checked.
- Back-to-back requests are allowed every cycle; throughput is 1 per clock.

Optional Feature:
- Macro: DATAMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from DataIn on write; the sweep writes INIT_VAL with its correct parity.
  - Extra output port ParityErr (1 bit). On a memory read (MemToReg=1) it is registered alongside DataOut and is 1 in cycle N+1 if the stored parity mismatches.
  - Forwarded reads recompute parity and never flag.
  - ParityErr resets to 0.
- When undefined: no parity storage and no ParityErr port.

Test Plan:
- DEPTH=16, AW=4, INIT_VAL=8'hA5: pulse Reset 1 cycle -> Busy high exactly 16 cycles; then read addr 0..15 with MemToReg=1 -> every DataOut = 8'hA5, ReadValid 1 cycle after each request.
- Write 8'h3C to addr 5 at edge N, read addr 5 at N+1 -> DataOut = 8'h3C at N+2. Simultaneous write 8'h77 and read of addr 9 -> DataOut = 8'h77 next cycle.
- MemToReg=0, ALUdata=8'h42, ReadEn=1 -> DataOut = 8'h42, ReadValid=1 next cycle. Alternating MemToReg each cycle at full rate -> correct interleaved results, no bubbles.
- Assert Reset at sweep cycle 7 -> ptr restarts at 0, Busy high for 16 more cycles after release. WriteEn=1 with DataIn=8'hFF during Busy -> no memory change afterwards.
- DEPTH=12, AW=4: write addr 13 -> no write, AddrErr=1 sticky. Read addr 14 -> DataOut = 0, ReadValid=1. AddrErr clears only on Reset.
- DATAMEM_PARITY_EN: force-flip one stored bit at addr 3 through the bench hierarchy, then read -> ParityErr=1 in the same cycle as DataOut. Clean read of addr 4 -> ParityErr=0.
